wb_arbiter: RTL and testbench

Round-robin Wishbone arbiter that shares one Wishbone master port (toward the slave interconnect) among `N_MASTERS` requesters (e.g. instruction fetch, data LSU, debug).

- Holds a grant for the full `CYC` tenure of the winning requester, so block and back-to-back cycles are not interrupted.
- Routes `ACK`/read data back to the winner only.
- Optionally aborts stalled cycles with a bus-timeout error.
- Sits between the core-side masters and the address-decoding interconnect.

---
 rtl/wb_arbiter_if.sv | 51 +++++
 rtl/wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bus bundle for wb_arbiter. It carries the requester-side ports (i_s_*/o_s_*),
// the shared master port (o_m_*/i_m_*), and the status outputs o_GNT/o_BUSY.
// Signal names keep the arbiter's point of view: i_* are driven into the arbiter.
interface wb_arbiter_if #(
    parameter int unsigned N_MASTERS  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    // Requester side
    logic [N_MASTERS-1:0]                 i_s_CYC;
    logic [N_MASTERS-1:0]                 i_s_STB;
    logic [N_MASTERS-1:0]                 i_s_WE;
    logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] i_s_ADDR;
    logic [N_MASTERS-1:0][DATA_WIDTH-1:0] i_s_DATA;
    logic [N_MASTERS-1:0][3:0]            i_s_SEL;
    logic [N_MASTERS-1:0][DATA_WIDTH-1:0] o_s_DATA;
    logic [N_MASTERS-1:0]                 o_s_ACK;
    logic [N_MASTERS-1:0]                 o_s_ERR;

    // Shared bus toward the interconnect
    logic [ADDR_WIDTH-1:0]                o_m_ADDR;
    logic [DATA_WIDTH-1:0]                o_m_DATA;
    logic [3:0]                           o_m_SEL;
    logic                                 o_m_WE;
    logic                                 o_m_CYC;
    logic                                 o_m_STB;
    logic [DATA_WIDTH-1:0]                i_m_DATA;
    logic                                 i_m_ACK;

    // Status
    logic [N_MASTERS-1:0]                 o_GNT;
    logic                                 o_BUSY;

    // Arbiter side: presents a slave port to each requester.
    modport slave (
        input  i_s_CYC, i_s_STB, i_s_WE, i_s_ADDR, i_s_DATA, i_s_SEL,
        input  i_m_DATA, i_m_ACK,
        output o_s_DATA, o_s_ACK, o_s_ERR,
        output o_m_ADDR, o_m_DATA, o_m_SEL, o_m_WE, o_m_CYC, o_m_STB,
        output o_GNT, o_BUSY
    );

    // Environment side: requesters plus the downstream slave.
    modport master (
        output i_s_CYC, i_s_STB, i_s_WE, i_s_ADDR, i_s_DATA, i_s_SEL,
        output i_m_DATA, i_m_ACK,
        input  o_s_DATA, o_s_ACK, o_s_ERR,
        input  o_m_ADDR, o_m_DATA, o_m_SEL, o_m_WE, o_m_CYC, o_m_STB,
        input  o_GNT, o_BUSY
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone arbiter. It shares one master port among N_MASTERS
// requesters and holds the grant for the winner's whole CYC tenure.
// Define WB_ARB_TIMEOUT_EN to build the stall-timeout counter and the ERR abort state.
// Without that define, a stalled slave keeps the grant and o_s_ERR stays 0.
module wb_arbiter #(
    parameter int unsigned N_MASTERS      = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_CLK,
    input  logic        i_RSTN,
    wb_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n_masters
        $error("wb_arbiter: N_MASTERS must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {StIdle, StOwned, StErr} state_e;
`else
    typedef enum logic [0:0] {StIdle, StOwned} state_e;
`endif

    state_e               state_q;
    logic [N_MASTERS-1:0] gnt_q;
    logic [IdxW-1:0]      win_q;
    logic [IdxW-1:0]      last_q;

    logic [N_MASTERS-1:0] req;
    logic                 pick_found;
    logic [IdxW-1:0]      pick_idx;
    logic [IdxW-1:0]      cand;
    logic                 win_cyc;
    logic                 win_stb;

    assign req     = bus.i_s_CYC & bus.i_s_STB;
    assign win_cyc = bus.i_s_CYC[win_q];
    assign win_stb = bus.i_s_STB[win_q];

`ifdef WB_ARB_TIMEOUT_EN
    logic [CntW-1:0] cnt_q;
    logic            stall;

    assign stall = win_stb & ~bus.i_m_ACK;
`endif

    // Round-robin search starting one past the last owner, wrapping modulo N_MASTERS.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            cand = IdxW'((32'(last_q) + k) % N_MASTERS);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Bus steering: mirror the winner while OWNED, route ACK/data/ERR to the winner only.
    always_comb begin
        bus.o_m_ADDR = '0;
        bus.o_m_DATA = '0;
        bus.o_m_SEL  = '0;
        bus.o_m_WE   = 1'b0;
        bus.o_m_CYC  = 1'b0;
        bus.o_m_STB  = 1'b0;
        bus.o_s_DATA = '0;
        bus.o_s_ACK  = '0;
        bus.o_s_ERR  = '0;
        if (state_q == StOwned) begin
            bus.o_m_ADDR          = bus.i_s_ADDR[win_q];
            bus.o_m_DATA          = bus.i_s_DATA[win_q];
            bus.o_m_SEL           = bus.i_s_SEL[win_q];
            bus.o_m_WE            = bus.i_s_WE[win_q];
            bus.o_m_CYC           = win_cyc;
            bus.o_m_STB           = win_stb;
            bus.o_s_ACK[win_q]    = bus.i_m_ACK;
            bus.o_s_DATA[win_q]   = bus.i_m_DATA;
        end
`ifdef WB_ARB_TIMEOUT_EN
        if (state_q == StErr) begin
            bus.o_s_ERR[win_q] = 1'b1;
        end
`endif
    end

    assign bus.o_GNT  = gnt_q;
    assign bus.o_BUSY = (state_q != StIdle);

    // Arbitration FSM with registered grant, round-robin pointer and stall counter.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTN) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            win_q   <= '0;
            last_q  <= IdxW'(N_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        state_q <= StOwned;
                        win_q   <= pick_idx;
                        gnt_q   <= N_MASTERS'(1) << pick_idx;
                    end
                end
                StOwned: begin
                    // Dropping CYC ends the tenure, with or without a final ACK.
                    if (!win_cyc) begin
                        state_q <= StIdle;
                        gnt_q   <= '0;
                        last_q  <= win_q;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (stall) begin
                        if (cnt_q != CntW'(TIMEOUT_CYCLES)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        // Counter reaches the limit on this edge; an ACK would have cleared stall.
                        if (cnt_q >= CntW'(TIMEOUT_CYCLES - 1)) begin
                            state_q <= StErr;
                        end
                    end
                    if (!win_cyc || !stall) begin
                        cnt_q <= '0;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                StErr: begin
                    state_q <= StIdle;
                    gnt_q   <= '0;
                    last_q  <= win_q;
                    cnt_q   <= '0;
                end
`endif
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scoreboard bench for wb_arbiter (N_MASTERS=2, TIMEOUT_CYCLES=4).
// Grants and ACK/ERR responses are queued as stimulus is issued and popped by a monitor.
module tb_wb_arbiter;
    localparam int unsigned N  = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.N_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    wb_arbiter #(
        .N_MASTERS      (N),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_CLK  (clk),
        .i_RSTN (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [N-1:0]         ack;
        logic [N-1:0]         err;
        logic [N-1:0][DW-1:0] data;
    } rsp_t;

    rsp_t         exp_rsp[$];
    logic [N-1:0] exp_gnt[$];
    int           n_checks = 0;
    int           n_err    = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_rsp(input logic [N-1:0] ack, input logic [N-1:0] err,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        rsp_t r;
        r.ack     = ack;
        r.err     = err;
        r.data[0] = d0;
        r.data[1] = d1;
        exp_rsp.push_back(r);
    endtask

    task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.i_s_CYC[m]  = cyc;
        bus.i_s_STB[m]  = stb;
        bus.i_s_WE[m]   = we;
        bus.i_s_ADDR[m] = addr;
        bus.i_s_DATA[m] = data;
        bus.i_s_SEL[m]  = 4'hF;
    endtask

    task automatic slave(input logic ack, input logic [DW-1:0] data);
        bus.i_m_ACK  = ack;
        bus.i_m_DATA = data;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expected grant on each new non-zero o_GNT and an expected
    // response whenever any ACK or ERR is presented.
    initial begin
        logic [N-1:0] gnt_prev;
        rsp_t         e;
        gnt_prev = '0;
        forever begin
            @(negedge clk);
            if (bus.o_GNT != gnt_prev && bus.o_GNT != '0) begin
                if (exp_gnt.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL gnt_unexpected: got %b, none required", bus.o_GNT);
                end else begin
                    chk("gnt_order", 64'(bus.o_GNT), 64'(exp_gnt.pop_front()));
                end
            end
            gnt_prev = bus.o_GNT;
            if (|bus.o_s_ACK || |bus.o_s_ERR) begin
                if (exp_rsp.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got ack=%b err=%b, none required",
                             bus.o_s_ACK, bus.o_s_ERR);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_ack", 64'(bus.o_s_ACK), 64'(e.ack));
                    chk("rsp_err", 64'(bus.o_s_ERR), 64'(e.err));
                    chk("rsp_data", 64'(bus.o_s_DATA), 64'(e.data));
                end
            end
        end
    end

    initial begin
        bus.i_s_CYC  = '0;
        bus.i_s_STB  = '0;
        bus.i_s_WE   = '0;
        bus.i_s_ADDR = '0;
        bus.i_s_DATA = '0;
        bus.i_s_SEL  = '0;
        slave(1'b0, '0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_gnt", 64'(bus.o_GNT), 64'd0);
        chk("rst_busy", 64'(bus.o_BUSY), 64'd0);
        chk("rst_m_cyc_stb", 64'({bus.o_m_CYC, bus.o_m_STB}), 64'd0);
        chk("rst_s_ack_err", 64'({bus.o_s_ACK, bus.o_s_ERR}), 64'd0);
        chk("rst_s_data", 64'(bus.o_s_DATA), 64'd0);
        next();
        rst_n = 1'b1;
        next();

        // Simultaneous request after reset: master 0 first, read acked after 3 stalls.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
        drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'h1111_1111);
        exp_gnt.push_back(2'b01);
        next();
        @(negedge clk);
        chk("lat_m_cyc", 64'(bus.o_m_CYC), 64'd1);
        chk("lat_m_addr", 64'(bus.o_m_ADDR), 64'h8000_0010);
        chk("lat_m_we", 64'(bus.o_m_WE), 64'd0);
        chk("lat_busy", 64'(bus.o_BUSY), 64'd1);
        next();
        next();
        next();
        slave(1'b1, 32'hDEAD_BEEF);
        push_rsp(2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0);
        next();
        slave(1'b0, 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_gnt.push_back(2'b10);
        next();
        @(negedge clk);
        chk("idle_gap_gnt", 64'(bus.o_GNT), 64'd0);
        chk("idle_gap_cyc", 64'(bus.o_m_CYC), 64'd0);
        next();
        slave(1'b1, 32'h0000_00A5);
        push_rsp(2'b10, 2'b00, 32'h0, 32'h0000_00A5);
        @(negedge clk);
        chk("m1_gnt", 64'(bus.o_GNT), 64'b10);
        chk("m1_wdata", 64'(bus.o_m_DATA), 64'h1111_1111);
        chk("m1_we_sel", 64'({bus.o_m_WE, bus.o_m_SEL}), 64'h1F);
        next();
        slave(1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next();

        // Next contention goes back to master 0.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h8000_0014, 32'h0);
        drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h0);
        exp_gnt.push_back(2'b01);
        next();
        slave(1'b1, 32'h0000_0055);
        push_rsp(2'b01, 2'b00, 32'h0000_0055, 32'h0);
        next();
        slave(1'b0, 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_gnt.push_back(2'b10);
        next();
        next();

        // Master 1 holds CYC over 4 back-to-back writes while master 0 requests.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h8000_0020, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 1'b1, 1'b1, 1'b1, AW'(32'h2000 + 4 * k), DW'(32'hB000_0000 + k));
            slave(1'b1, DW'(32'hC000_0000 + k));
            push_rsp(2'b10, 2'b00, 32'h0, DW'(32'hC000_0000 + k));
            @(negedge clk);
            chk("burst_gnt", 64'(bus.o_GNT), 64'b10);
            chk("burst_addr", 64'(bus.o_m_ADDR), 64'(32'h2000 + 4 * k));
            next();
        end
        slave(1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_gnt.push_back(2'b01);
        @(negedge clk);
        chk("burst_release_gnt", 64'(bus.o_GNT), 64'b10);
        next();
        @(negedge clk);
        chk("burst_idle_gnt", 64'(bus.o_GNT), 64'd0);
        next();

        // Master 0 owns and the slave never acks.
        @(negedge clk);
        chk("stall_gnt", 64'(bus.o_GNT), 64'b01);
        chk("stall_addr", 64'(bus.o_m_ADDR), 64'h8000_0020);
        next();
        next();
        next();
        @(negedge clk);
        chk("stall_no_err_yet", 64'(bus.o_s_ERR), 64'd0);
`ifdef WB_ARB_TIMEOUT_EN
        next();
        push_rsp(2'b00, 2'b01, 32'h0, 32'h0);
        @(negedge clk);
        chk("err_m_cyc_stb", 64'({bus.o_m_CYC, bus.o_m_STB}), 64'd0);
        chk("err_busy", 64'(bus.o_BUSY), 64'd1);
        next();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("err_then_idle", 64'({bus.o_BUSY, bus.o_GNT}), 64'd0);
        next();
`else
        next();
        @(negedge clk);
        chk("no_timeout_gnt_held", 64'(bus.o_GNT), 64'b01);
        chk("no_timeout_err", 64'(bus.o_s_ERR), 64'd0);
        chk("no_timeout_m_cyc", 64'(bus.o_m_CYC), 64'd1);
        next();
        slave(1'b1, 32'h0000_0077);
        push_rsp(2'b01, 2'b00, 32'h0000_0077, 32'h0);
        next();
        slave(1'b0, 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next();
        next();
`endif

        // ACK on the 4th stall cycle: no ERR.
        drive(1, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0);
        exp_gnt.push_back(2'b10);
        next();
        next();
        next();
        next();
        slave(1'b1, 32'h0000_0044);
        push_rsp(2'b10, 2'b00, 32'h0, 32'h0000_0044);
        next();
        slave(1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("ack_at_limit_no_err", 64'(bus.o_s_ERR), 64'd0);
        chk("ack_at_limit_busy", 64'(bus.o_BUSY), 64'd1);
        next();
        @(negedge clk);
        chk("ack_at_limit_idle", 64'({bus.o_BUSY, bus.o_s_ERR}), 64'd0);

        // Leave last=0, then reset mid-tenure of master 1.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h8000_0030, 32'h0);
        exp_gnt.push_back(2'b01);
        next();
        slave(1'b1, 32'h0000_0033);
        push_rsp(2'b01, 2'b00, 32'h0000_0033, 32'h0);
        next();
        slave(1'b0, 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_ABCD);
        exp_gnt.push_back(2'b10);
        next();
        next();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h8000_0040, 32'h0);
        @(negedge clk);
        chk("pre_reset_gnt", 64'(bus.o_GNT), 64'b10);
        next();
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        slave(1'b1, 32'h0000_0099);
        exp_gnt.push_back(2'b01);
        @(negedge clk);
        chk("mid_rst_gnt_busy", 64'({bus.o_GNT, bus.o_BUSY}), 64'd0);
        chk("mid_rst_m_cyc_stb", 64'({bus.o_m_CYC, bus.o_m_STB}), 64'd0);
        chk("mid_rst_m_addr", 64'(bus.o_m_ADDR), 64'd0);
        chk("mid_rst_s_ack_err", 64'({bus.o_s_ACK, bus.o_s_ERR}), 64'd0);
        chk("mid_rst_s_data", 64'(bus.o_s_DATA), 64'd0);
        next();
        slave(1'b1, 32'h0000_0012);
        push_rsp(2'b01, 2'b00, 32'h0000_0012, 32'h0);
        @(negedge clk);
        chk("post_rst_winner", 64'(bus.o_GNT), 64'b01);
        next();
        slave(1'b0, 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next();
        next();
        @(negedge clk);

        chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
        chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
